// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions for the decode stage: opcode encodings, control-word
// field encodings, the registered control-word payload and the FSM states.
package decode_stage_pkg;

    localparam int unsigned ISA_OPC_W = 7;
    localparam int unsigned FS_W      = 4;
    localparam int unsigned SH_W      = 5;

    typedef enum logic [ISA_OPC_W-1:0] {
        OP_NOP  = 7'h00,
        OP_ST   = 7'h01,
        OP_ADD  = 7'h02,
        OP_SUB  = 7'h05,
        OP_AND  = 7'h08,
        OP_OR   = 7'h09,
        OP_XOR  = 7'h0A,
        OP_NOT  = 7'h0B,
        OP_MOVB = 7'h0C,
        OP_LSR  = 7'h0D,
        OP_LSL  = 7'h0E,
        OP_LD   = 7'h21,
        OP_ADI  = 7'h42,
        OP_JMP  = 7'h44,
        OP_SBI  = 7'h45,
        OP_JML  = 7'h47,
        OP_ANI  = 7'h48,
        OP_ORI  = 7'h49,
        OP_XRI  = 7'h4A,
        OP_BZ   = 7'h60,
        OP_BNZ  = 7'h61,
        OP_AIU  = 7'h62,
        OP_SLT  = 7'h65,
        OP_SIU  = 7'h66,
        OP_JMR  = 7'h70,
        OP_HALT = 7'h7F
    } opcode_e;

    // Register-file write-data source
    typedef enum logic [1:0] {
        MD_ALU = 2'b00,
        MD_MEM = 2'b01,
        MD_SLT = 2'b10
    } md_e;

    // Branch select
    typedef enum logic [1:0] {
        BS_NONE = 2'b00,
        BS_BCND = 2'b01,
        BS_JMR  = 2'b10,
        BS_JMP  = 2'b11
    } bs_e;

    // Function-unit select
    typedef enum logic [FS_W-1:0] {
        FS_PASS = 4'b0000,
        FS_ADD  = 4'b0010,
        FS_SUB  = 4'b0101,
        FS_AND  = 4'b1000,
        FS_OR   = 4'b1001,
        FS_XOR  = 4'b1010,
        FS_NOT  = 4'b1011,
        FS_MOVB = 4'b1100,
        FS_LSR  = 4'b1101,
        FS_LSL  = 4'b1110
    } fs_e;

    typedef struct packed {
        logic rw;
        md_e  md;
        bs_e  bs;
        logic ps;
        logic mw;
        fs_e  fs;
        logic ma;
        logic mb;
        logic cs;
        logic illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        rw: 1'b0, md: MD_ALU, bs: BS_NONE, ps: 1'b0, mw: 1'b0,
        fs: FS_PASS, ma: 1'b0, mb: 1'b0, cs: 1'b0, illegal: 1'b0
    };

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Register busy scoreboard: one bit per architectural register.
// Ports: set_en/set_addr mark a register busy, clr_mask clears any set of
// registers, bits is the registered busy vector. A set beats a same-cycle clear.
module reg_scoreboard
    import decode_stage_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic [NREGS-1:0] clr_mask,
    output logic [NREGS-1:0] bits
);

    logic [NREGS-1:0] bits_d;

    // Clear first, then set, so a same-cycle set of the same bit wins
    always_comb begin
        bits_d = bits & ~clr_mask;
        if (set_en) begin
            bits_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else begin
            bits <= bits_d;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: splits the instruction word into fields, decodes
// the control word, stalls on RAW hazards via the register scoreboard, and
// holds the decoded bundle in an output register with a valid/ready handshake.
// Ports: clk/rst_n; in_valid/in_ready/in_inst input handshake; out_valid/
// out_ready plus registered fields and control word; wb_valid/wb_addr release
// a busy register; flush cancels the held bundle; resume leaves HALTED;
// halted reflects the HALTED state.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned INST_W = 32,
    parameter int unsigned OPC_W  = 7,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned IMM_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [REG_W-1:0]  out_dr,
    output logic [REG_W-1:0]  out_sa,
    output logic [REG_W-1:0]  out_sb,
    output logic [IMM_W-1:0]  out_imm,
    output logic [SH_W-1:0]   out_sh,
    output logic              out_rw,
    output logic [1:0]        out_md,
    output logic [1:0]        out_bs,
    output logic              out_ps,
    output logic              out_mw,
    output logic [FS_W-1:0]   out_fs,
    output logic              out_ma,
    output logic              out_mb,
    output logic              out_cs,
    output logic              out_illegal,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic              flush,
    input  logic              resume,
    output logic              halted
);

    localparam int unsigned NREGS = 1 << REG_W;

    // Field extraction, packed from the MSB
    logic [OPC_W-1:0] f_opcode;
    logic [REG_W-1:0] f_dr, f_sa, f_sb;
    logic [IMM_W-1:0] f_imm;
    logic [SH_W-1:0]  f_sh;
    opcode_e          op;

    assign f_opcode = in_inst[INST_W-1 -: OPC_W];
    assign f_dr     = in_inst[INST_W-OPC_W-1 -: REG_W];
    assign f_sa     = in_inst[INST_W-OPC_W-REG_W-1 -: REG_W];
    assign f_sb     = in_inst[INST_W-OPC_W-2*REG_W-1 -: REG_W];
    assign f_imm    = in_inst[IMM_W-1:0];
    assign f_sh     = in_inst[SH_W-1:0];
    assign op       = opcode_e'(ISA_OPC_W'(f_opcode));

    // Control-word decode; unknown opcodes keep NOP controls and flag illegal
    ctrl_t ctrl;
    logic  use_a, use_b;

    always_comb begin
        ctrl = CTRL_NOP;
        case (op)
            OP_NOP:  ;
            OP_HALT: ;
            OP_ADD:  begin ctrl.rw = 1'b1; ctrl.fs = FS_ADD;  end
            OP_SUB:  begin ctrl.rw = 1'b1; ctrl.fs = FS_SUB;  end
            OP_SLT:  begin ctrl.rw = 1'b1; ctrl.fs = FS_SUB;  ctrl.md = MD_SLT; end
            OP_AND:  begin ctrl.rw = 1'b1; ctrl.fs = FS_AND;  end
            OP_OR:   begin ctrl.rw = 1'b1; ctrl.fs = FS_OR;   end
            OP_XOR:  begin ctrl.rw = 1'b1; ctrl.fs = FS_XOR;  end
            OP_NOT:  begin ctrl.rw = 1'b1; ctrl.fs = FS_NOT;  end
            OP_MOVB: begin ctrl.rw = 1'b1; ctrl.fs = FS_MOVB; end
            OP_LSR:  begin ctrl.rw = 1'b1; ctrl.fs = FS_LSR;  end
            OP_LSL:  begin ctrl.rw = 1'b1; ctrl.fs = FS_LSL;  end
            OP_LD:   begin ctrl.rw = 1'b1; ctrl.md = MD_MEM;  end
            OP_ST:   begin ctrl.mw = 1'b1; end
            OP_ADI:  begin ctrl.rw = 1'b1; ctrl.fs = FS_ADD; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
            OP_SBI:  begin ctrl.rw = 1'b1; ctrl.fs = FS_SUB; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
            OP_ANI:  begin ctrl.rw = 1'b1; ctrl.fs = FS_AND; ctrl.mb = 1'b1; end
            OP_ORI:  begin ctrl.rw = 1'b1; ctrl.fs = FS_OR;  ctrl.mb = 1'b1; end
            OP_XRI:  begin ctrl.rw = 1'b1; ctrl.fs = FS_XOR; ctrl.mb = 1'b1; end
            OP_AIU:  begin ctrl.rw = 1'b1; ctrl.fs = FS_ADD; ctrl.mb = 1'b1; end
            OP_SIU:  begin ctrl.rw = 1'b1; ctrl.fs = FS_SUB; ctrl.mb = 1'b1; end
            OP_JMR:  begin ctrl.bs = BS_JMR; end
            OP_BZ:   begin ctrl.bs = BS_BCND; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
            OP_BNZ:  begin ctrl.bs = BS_BCND; ctrl.ps = 1'b1; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
            OP_JMP:  begin ctrl.bs = BS_JMP; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
            OP_JML:  begin ctrl.rw = 1'b1; ctrl.bs = BS_JMP; ctrl.ma = 1'b1; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    // Source-register usage feeding the hazard check
    always_comb begin
        use_a = !ctrl.illegal && !ctrl.ma &&
                !(op inside {OP_NOP, OP_HALT, OP_JMP, OP_MOVB});
        use_b = !ctrl.mb &&
                (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOVB, OP_SLT, OP_ST});
    end

    // Scoreboard and handshake
    logic [NREGS-1:0] sb_bits;
    logic [NREGS-1:0] clr_mask;
    logic             hazard;
    logic             accept;
    ctrl_t            ctrl_q;

    assign hazard   = (use_a && sb_bits[f_sa]) || (use_b && sb_bits[f_sb]);
    assign in_ready = !halted && !hazard && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Writeback releases its register; a flush releases the cancelled destination
    always_comb begin
        clr_mask = '0;
        if (wb_valid) begin
            clr_mask[wb_addr] = 1'b1;
        end
        if (flush && out_valid && ctrl_q.rw) begin
            clr_mask[out_dr] = 1'b1;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (REG_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept && ctrl.rw),
        .set_addr (f_dr),
        .clr_mask (clr_mask),
        .bits     (sb_bits)
    );

    // Output bundle register; flush beats out_ready, fields hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            ctrl_q     <= '0;
            out_opcode <= '0;
            out_dr     <= '0;
            out_sa     <= '0;
            out_sb     <= '0;
            out_imm    <= '0;
            out_sh     <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                ctrl_q     <= ctrl;
                out_opcode <= f_opcode;
                out_dr     <= f_dr;
                out_sa     <= f_sa;
                out_sb     <= f_sb;
                out_imm    <= f_imm;
                out_sh     <= f_sh;
            end
        end
    end

    assign out_rw      = ctrl_q.rw;
    assign out_md      = ctrl_q.md;
    assign out_bs      = ctrl_q.bs;
    assign out_ps      = ctrl_q.ps;
    assign out_mw      = ctrl_q.mw;
    assign out_fs      = ctrl_q.fs;
    assign out_ma      = ctrl_q.ma;
    assign out_mb      = ctrl_q.mb;
    assign out_cs      = ctrl_q.cs;
    assign out_illegal = ctrl_q.illegal;

    // RUN/HALTED control
    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (accept && op == OP_HALT) begin
                state_d = ST_HALTED;
            end
        end else begin
            if (resume) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_dr, out_sa, out_sb;
    logic [14:0] out_imm;
    logic [4:0]  out_sh;
    logic        out_rw;
    logic [1:0]  out_md, out_bs;
    logic        out_ps, out_mw;
    logic [3:0]  out_fs;
    logic        out_ma, out_mb, out_cs, out_illegal;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        resume;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_dr      (out_dr),
        .out_sa      (out_sa),
        .out_sb      (out_sb),
        .out_imm     (out_imm),
        .out_sh      (out_sh),
        .out_rw      (out_rw),
        .out_md      (out_md),
        .out_bs      (out_bs),
        .out_ps      (out_ps),
        .out_mw      (out_mw),
        .out_fs      (out_fs),
        .out_ma      (out_ma),
        .out_mb      (out_mb),
        .out_cs      (out_cs),
        .out_illegal (out_illegal),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .resume      (resume),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input int dr, input int sa, input int sb);
        return {op, 5'(dr), 5'(sa), 5'(sb), 10'b0};
    endfunction

    function automatic logic [31:0] mki(input logic [6:0] op, input int dr, input int sa, input logic [14:0] imm);
        return {op, 5'(dr), 5'(sa), imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb_clear(input int addr);
        wb_valid = 1'b1;
        wb_addr  = 5'(addr);
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_inst   = '0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        flush     = 1'b0;
        resume    = 1'b0;
        rst_n     = 1'b0;

        // Reset state
        #12;
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_rw",     32'(out_rw), 32'd0);
        check("rst_opcode", 32'(out_opcode), 32'd0);
        check("rst_illeg",  32'(out_illegal), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_sb",     32'(dut.sb_bits), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back ADDs
        in_valid = 1'b1;
        in_inst  = mk(OP_ADD, 1, 2, 3);
        settle();
        check("b2b_rdy0", 32'(in_ready), 32'd1);
        tick();
        check("b2b_v0",   32'(out_valid), 32'd1);
        check("b2b_dr0",  32'(out_dr), 32'd1);
        check("b2b_sa0",  32'(out_sa), 32'd2);
        check("b2b_sb0",  32'(out_sb), 32'd3);
        check("b2b_fs0",  32'(out_fs), 32'b0010);
        check("b2b_rw0",  32'(out_rw), 32'd1);
        check("b2b_ill0", 32'(out_illegal), 32'd0);
        in_inst = mk(OP_ADD, 4, 5, 6);
        settle();
        check("b2b_rdy1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_v1",   32'(out_valid), 32'd1);
        check("b2b_dr1",  32'(out_dr), 32'd4);
        check("b2b_op1",  32'(out_opcode), 32'h02);
        check("b2b_fs1",  32'(out_fs), 32'b0010);
        tick();
        check("b2b_v2",   32'(out_valid), 32'd0);
        check("b2b_sb",   32'(dut.sb_bits), 32'h0000_0012);
        wb_clear(1);
        wb_clear(4);
        check("b2b_sbclr", 32'(dut.sb_bits), 32'd0);

        // RAW hazard on r1
        in_valid = 1'b1;
        in_inst  = mk(OP_ADD, 1, 2, 3);
        tick();
        in_inst = mk(OP_SUB, 2, 1, 3);
        settle();
        check("raw_blk0", 32'(in_ready), 32'd0);
        tick();
        check("raw_blk1", 32'(in_ready), 32'd0);
        check("raw_v0",   32'(out_valid), 32'd0);
        wb_valid = 1'b1;
        wb_addr  = 5'd1;
        settle();
        check("raw_blk2", 32'(in_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        settle();
        check("raw_rdy",  32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("raw_v1",   32'(out_valid), 32'd1);
        check("raw_op",   32'(out_opcode), 32'h05);
        check("raw_fs",   32'(out_fs), 32'b0101);
        check("raw_dr",   32'(out_dr), 32'd2);
        tick();
        check("raw_v2",   32'(out_valid), 32'd0);
        wb_clear(2);

        // Backpressure with LD held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = mk(OP_LD, 3, 0, 0);
        tick();
        in_inst = mk(OP_ADD, 5, 6, 7);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_rdy", 32'(in_ready), 32'd0);
            check("bp_v",   32'(out_valid), 32'd1);
            check("bp_md",  32'(out_md), 32'b01);
            check("bp_dr",  32'(out_dr), 32'd3);
            check("bp_op",  32'(out_opcode), 32'h21);
            check("bp_rw",  32'(out_rw), 32'd1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_done", 32'(out_valid), 32'd0);
        wb_clear(3);

        // ADI r7 accepted while r7 is written back
        in_valid = 1'b1;
        in_inst  = mki(OP_ADI, 7, 0, 15'h1234);
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        check("sc_sb7",  32'(dut.sb_bits[7]), 32'd1);
        check("sc_mb",   32'(out_mb), 32'd1);
        check("sc_cs",   32'(out_cs), 32'd1);
        check("sc_fs",   32'(out_fs), 32'b0010);
        check("sc_imm",  32'(out_imm), 32'h1234);
        check("sc_sh",   32'(out_sh), 32'h14);
        tick();
        wb_clear(7);
        check("sc_sbclr", 32'(dut.sb_bits), 32'd0);

        // HALT then ADD
        in_valid = 1'b1;
        in_inst  = mk(OP_HALT, 0, 0, 0);
        tick();
        check("h_v",      32'(out_valid), 32'd1);
        check("h_op",     32'(out_opcode), 32'h7F);
        check("h_rw",     32'(out_rw), 32'd0);
        check("h_halted", 32'(halted), 32'd1);
        in_inst = mk(OP_ADD, 8, 9, 10);
        settle();
        check("h_blk0",   32'(in_ready), 32'd0);
        tick();
        check("h_v2",     32'(out_valid), 32'd0);
        check("h_blk1",   32'(in_ready), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("h_flush",  32'(halted), 32'd1);
        settle();
        check("h_blk2",   32'(in_ready), 32'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("h_resume", 32'(halted), 32'd0);
        settle();
        check("h_rdy",    32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("h_addv",   32'(out_valid), 32'd1);
        check("h_adddr",  32'(out_dr), 32'd8);
        tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("h_runres", 32'(halted), 32'd0);
        wb_clear(8);

        // Flush a held ADD r9
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = mk(OP_ADD, 9, 0, 0);
        tick();
        in_valid = 1'b0;
        check("f_v",    32'(out_valid), 32'd1);
        check("f_sb9",  32'(dut.sb_bits[9]), 32'd1);
        flush = 1'b1;
        settle();
        check("f_rdy",  32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("f_v2",   32'(out_valid), 32'd0);
        check("f_sb9c", 32'(dut.sb_bits[9]), 32'd0);
        out_ready = 1'b1;

        // Unknown opcode
        in_valid = 1'b1;
        in_inst  = mk(7'h33, 11, 0, 0);
        settle();
        check("i_rdy",  32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("i_v",    32'(out_valid), 32'd1);
        check("i_ill",  32'(out_illegal), 32'd1);
        check("i_rw",   32'(out_rw), 32'd0);
        check("i_mw",   32'(out_mw), 32'd0);
        check("i_sb11", 32'(dut.sb_bits[11]), 32'd0);
        tick();
        check("i_v2",   32'(out_valid), 32'd0);

        // Asynchronous reset with a bundle held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = mk(OP_ADD, 12, 0, 0);
        tick();
        in_valid = 1'b0;
        check("r_v",    32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_v0",   32'(out_valid), 32'd0);
        check("r_rw",   32'(out_rw), 32'd0);
        check("r_op",   32'(out_opcode), 32'd0);
        check("r_dr",   32'(out_dr), 32'd0);
        check("r_fs",   32'(out_fs), 32'd0);
        check("r_sb",   32'(dut.sb_bits), 32'd0);
        check("r_halt", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("r_post", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
